// File: rtl/br_pred_ctrl.sv
// Branch predictor: direct-mapped BTB with 2-bit counters, EX-stage mispredict detection and redirect.
// Latency: prediction and flush/redirect are combinational (0 cycles); table training lands 1 cycle later.
// Backpressure: stall_i suppresses flush, table writes and perf counting; optional BP_PERF_CNT_EN adds perf counters.
module br_pred_ctrl #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_uncbr_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_target_i,
    input  logic        ex_pc_sel_i,
    input  logic [31:0] ex_target_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_br_cnt_o,
    output logic [31:0] perf_misp_cnt_o
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
        logic             unc;
    } btb_ent_t;

    btb_ent_t tbl_q [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    btb_ent_t         if_ent;
    logic             if_hit;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    btb_ent_t         ex_ent;
    logic             ex_hit;

    logic             res;
    logic             is_jmp;
    logic             misp;
    logic             upd_vld;
    btb_ent_t         upd_ent;

    logic             unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[31:IDX_W+TAG_W+2], if_pc_i[1:0]};

    // Fetch-side lookup reads the registered table, so a same-cycle EX write is not seen here.
    assign if_idx = if_pc_i[IDX_W+1:2];
    assign if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign if_ent = tbl_q[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

    assign pred_taken_o  = if_hit && (if_ent.unc || if_ent.ctr[1]);
    assign pred_target_o = if_hit ? if_ent.target : 32'd0;

    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_ent = tbl_q[ex_idx];
    assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

    assign res    = ex_valid_i && !stall_i && !rst_i;
    assign is_jmp = ex_is_br_i || ex_is_uncbr_i;

    // A non-branch that arrived with a taken prediction is a BTB alias and must be undone.
    always_comb begin
        misp = 1'b0;
        if (is_jmp) begin
            misp = (ex_pc_sel_i != ex_pred_taken_i) ||
                   (ex_pc_sel_i && ex_pred_taken_i && (ex_target_i != ex_pred_target_i));
        end else begin
            misp = ex_pred_taken_i;
        end
    end

    assign flush_o       = res && misp;
    assign redirect_pc_o = !flush_o    ? 32'd0 :
                           ex_pc_sel_i ? ex_target_i : (ex_pc_i + 32'd4);

    always_comb begin
        upd_vld = 1'b0;
        upd_ent = ex_ent;
        if (res) begin
            if (is_jmp) begin
                if (ex_hit) begin
                    upd_vld = 1'b1;
                    if (ex_is_uncbr_i) begin
                        upd_ent.ctr    = 2'b11;
                        upd_ent.target = ex_target_i;
                        upd_ent.unc    = 1'b1;
                    end else if (ex_pc_sel_i) begin
                        upd_ent.ctr    = (ex_ent.ctr == 2'b11) ? 2'b11 : ex_ent.ctr + 2'd1;
                        upd_ent.target = ex_target_i;
                    end else begin
                        upd_ent.ctr    = (ex_ent.ctr == 2'b00) ? 2'b00 : ex_ent.ctr - 2'd1;
                    end
                end else if (ex_pc_sel_i) begin
                    // Miss on a taken branch/jump: allocate, replacing whatever aliased here.
                    upd_vld        = 1'b1;
                    upd_ent.valid  = 1'b1;
                    upd_ent.tag    = ex_tag;
                    upd_ent.target = ex_target_i;
                    upd_ent.unc    = ex_is_uncbr_i;
                    upd_ent.ctr    = ex_is_uncbr_i ? 2'b11 : 2'b10;
                end
            end else if (ex_hit) begin
                upd_vld       = 1'b1;
                upd_ent.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i].valid  <= 1'b0;
                tbl_q[i].tag    <= '0;
                tbl_q[i].target <= 32'd0;
                tbl_q[i].ctr    <= 2'b01;
                tbl_q[i].unc    <= 1'b0;
            end
        end else if (upd_vld) begin
            tbl_q[ex_idx] <= upd_ent;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_misp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_br_q   <= 32'd0;
            perf_misp_q <= 32'd0;
        end else begin
            if (res && is_jmp && (perf_br_q != 32'hFFFF_FFFF)) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (flush_o && (perf_misp_q != 32'hFFFF_FFFF)) begin
                perf_misp_q <= perf_misp_q + 32'd1;
            end
        end
    end

    assign perf_br_cnt_o   = perf_br_q;
    assign perf_misp_cnt_o = perf_misp_q;
`endif

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed bench for br_pred_ctrl: reset, allocation, counter saturation, jumps, aliasing, stall and reset priority.
module tb_br_pred_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        stall_i;
    logic        ex_valid_i;
    logic [31:0] ex_pc_i;
    logic        ex_is_br_i;
    logic        ex_is_uncbr_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic        ex_pc_sel_i;
    logic [31:0] ex_target_i;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt_o;
    logic [31:0] perf_misp_cnt_o;
`endif

    int err = 0;
    int chk = 0;

    always #5 clk_i = ~clk_i;

    br_pred_ctrl #(.IDX_W(6), .TAG_W(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .if_pc_i          (if_pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .stall_i          (stall_i),
        .ex_valid_i       (ex_valid_i),
        .ex_pc_i          (ex_pc_i),
        .ex_is_br_i       (ex_is_br_i),
        .ex_is_uncbr_i    (ex_is_uncbr_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .ex_pc_sel_i      (ex_pc_sel_i),
        .ex_target_i      (ex_target_i),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_br_cnt_o    (perf_br_cnt_o),
        .perf_misp_cnt_o  (perf_misp_cnt_o)
`endif
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic ex_drv(input logic v, input logic [31:0] pc, input logic br, input logic unc,
                          input logic pt, input logic [31:0] ptgt, input logic sel,
                          input logic [31:0] tgt);
        ex_valid_i       = v;
        ex_pc_i          = pc;
        ex_is_br_i       = br;
        ex_is_uncbr_i    = unc;
        ex_pred_taken_i  = pt;
        ex_pred_target_i = ptgt;
        ex_pc_sel_i      = sel;
        ex_target_i      = tgt;
    endtask

    task automatic ex_idle;
        ex_drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic test_reset;
        rst_i   = 1'b1;
        stall_i = 1'b0;
        if_pc_i = 32'h100;
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL rst_flush_held: got %0b want 0", flush_o); end
        tick();
        rst_i = 1'b0;
        ex_idle();
        #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL rst_pred_taken: got %0b want 0", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h0) begin err++; $display("FAIL rst_pred_target: got %0h want 0", pred_target_o); end
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL rst_flush: got %0b want 0", flush_o); end
        chk++; if (redirect_pc_o !== 32'h0) begin err++; $display("FAIL rst_redirect: got %0h want 0", redirect_pc_o); end
        ex_drv(1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL invalid_ex_flush: got %0b want 0", flush_o); end
    endtask

    task automatic test_cond_alloc;
        tick();
        if_pc_i = 32'h100;
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL alloc_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h80) begin err++; $display("FAIL alloc_redirect: got %0h want 80", redirect_pc_o); end
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL same_cycle_old: got %0b want 0", pred_taken_o); end
        tick();
        ex_idle();
        #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL alloc_pred_taken: got %0b want 1", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h80) begin err++; $display("FAIL alloc_pred_target: got %0h want 80", pred_target_o); end
    endtask

    task automatic test_counter;
        // ctr 10 -> 01 with mispredict
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL nt1_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h104) begin err++; $display("FAIL nt1_redirect: got %0h want 104", redirect_pc_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL nt1_pred: got %0b want 0", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h80) begin err++; $display("FAIL nt1_target: got %0h want 80", pred_target_o); end
        // ctr 01 -> 00, correctly predicted
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL nt2_flush: got %0b want 0", flush_o); end
        chk++; if (redirect_pc_o !== 32'h0) begin err++; $display("FAIL nt2_redirect: got %0h want 0", redirect_pc_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL nt2_pred: got %0b want 0", pred_taken_o); end
        // ctr 00 -> 01: still not taken, proves the decrement stopped at 00
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL t1_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h80) begin err++; $display("FAIL t1_redirect: got %0h want 80", redirect_pc_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL satdec_pred: got %0b want 0", pred_taken_o); end
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL t2_pred: got %0b want 1", pred_taken_o); end
        // ctr 10 -> 11 -> 11, then one not-taken leaves it at 10 (still taken)
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL t3_flush: got %0b want 0", flush_o); end
        tick();
        tick();
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80);
        #1;
        chk++; if (redirect_pc_o !== 32'h104) begin err++; $display("FAIL sat_nt_redirect: got %0h want 104", redirect_pc_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL satinc_pred: got %0b want 1", pred_taken_o); end
    endtask

    task automatic test_uncond;
        ex_drv(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL jal_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h400) begin err++; $display("FAIL jal_redirect: got %0h want 400", redirect_pc_o); end
        tick(); ex_idle(); if_pc_i = 32'h200; #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL jal_pred: got %0b want 1", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h400) begin err++; $display("FAIL jal_target: got %0h want 400", pred_target_o); end
        if_pc_i = 32'h100; #1;
        chk++; if (pred_target_o !== 32'h0) begin err++; $display("FAIL replaced_target: got %0h want 0", pred_target_o); end
        ex_drv(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h500);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL jalr_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h500) begin err++; $display("FAIL jalr_redirect: got %0h want 500", redirect_pc_o); end
        tick(); ex_idle(); if_pc_i = 32'h200; #1;
        chk++; if (pred_target_o !== 32'h500) begin err++; $display("FAIL jalr_target: got %0h want 500", pred_target_o); end
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL jalr_pred: got %0b want 1", pred_taken_o); end
        ex_drv(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL jal_hit_flush: got %0b want 0", flush_o); end
        tick();
    endtask

    task automatic test_alias;
        if_pc_i = 32'h100;
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL alias_setup_pred: got %0b want 1", pred_taken_o); end
        ex_drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL alias_flush: got %0b want 1", flush_o); end
        chk++; if (redirect_pc_o !== 32'h104) begin err++; $display("FAIL alias_redirect: got %0h want 104", redirect_pc_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL alias_inval_pred: got %0b want 0", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h0) begin err++; $display("FAIL alias_inval_target: got %0h want 0", pred_target_o); end
    endtask

    task automatic test_stall;
        stall_i = 1'b1;
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL stall_flush: got %0b want 0", flush_o); end
        chk++; if (redirect_pc_o !== 32'h0) begin err++; $display("FAIL stall_redirect: got %0h want 0", redirect_pc_o); end
        tick(); stall_i = 1'b0; ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL stall_no_write: got %0b want 0", pred_taken_o); end
        ex_drv(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
        #1;
        chk++; if (flush_o !== 1'b1) begin err++; $display("FAIL unstall_flush: got %0b want 1", flush_o); end
        tick(); ex_idle(); #1;
        chk++; if (pred_taken_o !== 1'b1) begin err++; $display("FAIL unstall_pred: got %0b want 1", pred_taken_o); end
`ifdef BP_PERF_CNT_EN
        chk++; if (perf_br_cnt_o !== 32'd13) begin err++; $display("FAIL perf_br: got %0d want 13", perf_br_cnt_o); end
        chk++; if (perf_misp_cnt_o !== 32'd10) begin err++; $display("FAIL perf_misp: got %0d want 10", perf_misp_cnt_o); end
`endif
    endtask

    task automatic test_reset_update;
        rst_i = 1'b1;
        ex_drv(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h400);
        #1;
        chk++; if (flush_o !== 1'b0) begin err++; $display("FAIL rstupd_flush: got %0b want 0", flush_o); end
        tick(); rst_i = 1'b0; ex_idle(); if_pc_i = 32'h100; #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL rstupd_clear_100: got %0b want 0", pred_taken_o); end
        if_pc_i = 32'h200; #1;
        chk++; if (pred_taken_o !== 1'b0) begin err++; $display("FAIL rstupd_no_write_200: got %0b want 0", pred_taken_o); end
        chk++; if (pred_target_o !== 32'h0) begin err++; $display("FAIL rstupd_target_200: got %0h want 0", pred_target_o); end
`ifdef BP_PERF_CNT_EN
        chk++; if (perf_br_cnt_o !== 32'd0) begin err++; $display("FAIL perf_br_rst: got %0d want 0", perf_br_cnt_o); end
        chk++; if (perf_misp_cnt_o !== 32'd0) begin err++; $display("FAIL perf_misp_rst: got %0d want 0", perf_misp_cnt_o); end
`endif
    endtask

    initial begin
        rst_i   = 1'b1;
        stall_i = 1'b0;
        if_pc_i = 32'h0;
        ex_idle();
        test_reset();
        test_cond_alloc();
        test_counter();
        test_uncond();
        test_alias();
        test_stall();
        test_reset_update();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
